// File: rtl/intc_prio_pkg.sv
// intc_prio_pkg: shared constants for the prioritised interrupt controller.
//   - register word indices of the host register map
//   - ICR bit positions
//   - FSM state encoding
//   - default NMI vector and the fixed NMI level
//   - mask helper functions used to drop bits of unimplemented sources
package intc_prio_pkg;

  // Register word indices (REG_A)
  localparam logic [2:0] REG_IPR0 = 3'd0;
  localparam logic [2:0] REG_IPR1 = 3'd1;
  localparam logic [2:0] REG_IPR2 = 3'd2;
  localparam logic [2:0] REG_IPR3 = 3'd3;
  localparam logic [2:0] REG_MODE = 3'd4;
  localparam logic [2:0] REG_PEND = 3'd5;
  localparam logic [2:0] REG_ICR  = 3'd6;

  // ICR bit positions
  localparam int ICR_NMIE = 0;
  localparam int ICR_NMIL = 1;

  // NMI presentation
  localparam logic [7:0] NMI_VEC_DEFAULT = 8'd11;
  localparam logic [3:0] NMI_LVL         = 4'd15;

  // FSM state encoding
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_REQ  = 2'd1;
  localparam fsm_state_t ST_HOLD = 2'd2;

  // One bit per implemented source.
  function automatic logic [31:0] src_mask(input int nsrc);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < nsrc) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Nibbles of IPR word w that belong to implemented sources.
  function automatic logic [31:0] ipr_word_mask(input int nsrc, input logic [1:0] w);
    logic [31:0] m;
    m = 32'd0;
    for (int k = 0; k < 8; k++) begin
      m[4*k +: 4] = ((int'(w) * 8 + k) < nsrc) ? 4'hF : 4'h0;
    end
    return m;
  endfunction

endpackage

// File: rtl/intc_edge_sync.sv
// intc_edge_sync: two-flop synchroniser for one asynchronous line plus an
// edge pulse. The pulse fires for one CE cycle when the synchronised level
// changes to the value of pol (pol=1: rising edge, pol=0: falling edge).
// Ports:
//   CLK, RST_N, CE  clock, async active-low reset, clock enable
//   async_in        asynchronous input line
//   pol             edge polarity selector
//   sync_lvl        synchronised level
//   edge_pulse      one-cycle edge indication (combinational from flops)
module intc_edge_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic async_in,
  input  logic pol,
  output logic sync_lvl,
  output logic edge_pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else if (CE) begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync_lvl   = sync_r;
  assign edge_pulse = (sync_r ^ prev_r) & ~(sync_r ^ pol);

endmodule

// File: rtl/intc_prio.sv
// intc_prio: prioritised interrupt controller with one NMI and NSRC maskable
// sources, a small host register file and an IDLE/REQ/HOLD presentation FSM.
// Ports:
//   CLK, RST_N, CE            clock, async active-low reset, clock enable
//   NMI_N                     asynchronous NMI pin (edge per ICR.NMIE)
//   SRC_IRQ[NSRC]             asynchronous source requests, active-high
//   INT_MASK[4]               CPU mask level; sources must exceed it
//   INT_REQ/INT_LVL/INT_VEC   registered request, level and vector to CPU
//   INT_ACK                   one-CE-cycle acceptance from CPU (only in REQ)
//   REG_A/DI/BE/WE/REQ/DO     host register port, registered read data
module intc_prio
  import intc_prio_pkg::*;
#(
  parameter int         NSRC     = 16,
  parameter int         VEC_BASE = 64,
  parameter logic [7:0] NMI_VEC  = NMI_VEC_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CE,
  input  logic            NMI_N,
  input  logic [NSRC-1:0] SRC_IRQ,
  input  logic [3:0]      INT_MASK,
  output logic            INT_REQ,
  output logic [3:0]      INT_LVL,
  output logic [7:0]      INT_VEC,
  input  logic            INT_ACK,
  input  logic [2:0]      REG_A,
  input  logic [31:0]     REG_DI,
  input  logic [3:0]      REG_BE,
  input  logic            REG_WE,
  input  logic            REG_REQ,
  output logic [31:0]     REG_DO
);

  localparam logic [31:0] SRC_MASK  = src_mask(NSRC);
  localparam logic [7:0]  VEC_BASE8 = 8'(VEC_BASE);

  // register file
  logic [31:0] ipr_r [4];
  logic [31:0] mode_r;
  logic [31:0] pend_r;
  logic        nmie_r;
  logic        nmi_pend_r;

  // presentation FSM
  fsm_state_t  state_r;
  logic        win_nmi_r;
  logic [4:0]  win_idx_r;
  logic        int_req_r;
  logic [3:0]  int_lvl_r;
  logic [7:0]  int_vec_r;
  logic [31:0] reg_do_r;

  // combinational helpers
  logic [31:0] src_lvl_s;
  logic [31:0] src_rise_s;
  logic        nmi_lvl_s;
  logic        nmi_edge_s;
  logic [3:0]  prio_s [32];
  logic        wr_s;
  logic        rd_s;
  logic        ack_s;
  logic [31:0] be_mask_s;
  logic [31:0] ipr_wm_s;
  logic [31:0] w1c_s;
  logic [31:0] ack_clr_s;
  logic [31:0] pend_nx_s;
  logic        nmi_pend_nx_s;
  logic [31:0] icr_s;
  logic        win_any_s;
  logic        win_nmi_s;
  logic [4:0]  win_idx_s;
  logic [3:0]  win_lvl_s;
  logic [7:0]  win_vec_s;
  logic        take_s;
  logic        cancel_s;

  // Synchronisers: one per implemented source (rising edge), one for NMI.
  for (genvar g = 0; g < 32; g++) begin : g_src
    if (g < NSRC) begin : g_on
      intc_edge_sync u_sync (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CE         (CE),
        .async_in   (SRC_IRQ[g]),
        .pol        (1'b1),
        .sync_lvl   (src_lvl_s[g]),
        .edge_pulse (src_rise_s[g])
      );
    end else begin : g_off
      assign src_lvl_s[g]  = 1'b0;
      assign src_rise_s[g] = 1'b0;
    end
    assign prio_s[g] = ipr_r[g / 8][(g % 8) * 4 +: 4];
  end

  // NMIE=1 arms the rising edge of NMI_N, NMIE=0 the falling edge.
  intc_edge_sync u_nmi_sync (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CE         (CE),
    .async_in   (NMI_N),
    .pol        (nmie_r),
    .sync_lvl   (nmi_lvl_s),
    .edge_pulse (nmi_edge_s)
  );

  assign wr_s      = CE & REG_REQ & REG_WE;
  assign rd_s      = CE & REG_REQ & ~REG_WE;
  assign ack_s     = CE & INT_ACK & (state_r == ST_REQ);
  assign be_mask_s = {{8{REG_BE[3]}}, {8{REG_BE[2]}}, {8{REG_BE[1]}}, {8{REG_BE[0]}}};
  assign ipr_wm_s  = be_mask_s & ipr_word_mask(NSRC, REG_A[1:0]);

  // write-1-clear and ACK clear vectors for the pending register
  always_comb begin
    w1c_s     = 32'd0;
    ack_clr_s = 32'd0;
    if (wr_s && (REG_A == REG_PEND)) begin
      w1c_s = REG_DI & be_mask_s;
    end else begin
      w1c_s = 32'd0;
    end
    if (ack_s && !win_nmi_r) begin
      ack_clr_s[win_idx_r] = 1'b1;
    end else begin
      ack_clr_s = 32'd0;
    end
  end

  // Level sources mirror their level; edge sources set on an edge, and a new
  // edge wins over a clear arriving in the same cycle.
  assign pend_nx_s = SRC_MASK & ((mode_r & src_lvl_s) |
                     (~mode_r & (src_rise_s | (pend_r & ~(ack_clr_s | w1c_s)))));
  assign nmi_pend_nx_s = nmi_edge_s | (nmi_pend_r & ~(ack_s & win_nmi_r));

  // arbitration: NMI first, else highest priority above mask, lowest index on tie
  always_comb begin
    win_any_s = 1'b0;
    win_nmi_s = 1'b0;
    win_idx_s = 5'd0;
    win_lvl_s = 4'd0;
    take_s    = 1'b0;
    if (nmi_pend_r) begin
      win_any_s = 1'b1;
      win_nmi_s = 1'b1;
      win_lvl_s = NMI_LVL;
    end else begin
      for (int i = 0; i < 32; i++) begin
        take_s    = pend_r[i] & (prio_s[i] > INT_MASK) & (prio_s[i] > win_lvl_s);
        win_any_s = win_any_s | take_s;
        win_idx_s = take_s ? 5'(i) : win_idx_s;
        win_lvl_s = take_s ? prio_s[i] : win_lvl_s;
      end
    end
  end

  assign win_vec_s = win_nmi_s ? NMI_VEC : (VEC_BASE8 + {3'd0, win_idx_s});

  // A frozen source winner is withdrawn when its pending drops or it is masked.
  assign cancel_s = ~win_nmi_r & (~pend_r[win_idx_r] | (prio_s[win_idx_r] <= INT_MASK));

  // ICR read view
  always_comb begin
    icr_s           = 32'd0;
    icr_s[ICR_NMIE] = nmie_r;
    icr_s[ICR_NMIL] = nmi_lvl_s;
  end

  // configuration registers: IPR words, MODE and ICR.NMIE with byte enables
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < 4; w++) begin
        ipr_r[w] <= 32'd0;
      end
      mode_r <= 32'd0;
      nmie_r <= 1'b0;
    end else if (wr_s) begin
      if (REG_A <= REG_IPR3) begin
        ipr_r[REG_A[1:0]] <= (ipr_r[REG_A[1:0]] & ~ipr_wm_s) | (REG_DI & ipr_wm_s);
      end
      if (REG_A == REG_MODE) begin
        mode_r <= (mode_r & ~(be_mask_s & SRC_MASK)) | (REG_DI & be_mask_s & SRC_MASK);
      end
      if ((REG_A == REG_ICR) && REG_BE[0]) begin
        nmie_r <= REG_DI[ICR_NMIE];
      end
    end
  end

  // pending state for sources and NMI
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_r     <= 32'd0;
      nmi_pend_r <= 1'b0;
    end else if (CE) begin
      pend_r     <= pend_nx_s;
      nmi_pend_r <= nmi_pend_nx_s;
    end
  end

  // presentation FSM: IDLE -> REQ on a winner, REQ -> HOLD on ACK, cancel to IDLE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      win_nmi_r <= 1'b0;
      win_idx_r <= 5'd0;
      int_req_r <= 1'b0;
      int_lvl_r <= 4'd0;
      int_vec_r <= 8'd0;
    end else if (CE) begin
      case (state_r)
        ST_IDLE: begin
          if (win_any_s) begin
            state_r   <= ST_REQ;
            int_req_r <= 1'b1;
            int_lvl_r <= win_lvl_s;
            int_vec_r <= win_vec_s;
            win_nmi_r <= win_nmi_s;
            win_idx_r <= win_idx_s;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            state_r   <= ST_HOLD;
            int_req_r <= 1'b0;
          end else if (cancel_s) begin
            state_r   <= ST_IDLE;
            int_req_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          int_req_r <= 1'b0;
        end
      endcase
    end
  end

  // registered read data, held between read requests
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reg_do_r <= 32'd0;
    end else if (rd_s) begin
      case (REG_A)
        REG_IPR0: reg_do_r <= ipr_r[0];
        REG_IPR1: reg_do_r <= ipr_r[1];
        REG_IPR2: reg_do_r <= ipr_r[2];
        REG_IPR3: reg_do_r <= ipr_r[3];
        REG_MODE: reg_do_r <= mode_r;
        REG_PEND: reg_do_r <= pend_r;
        REG_ICR:  reg_do_r <= icr_s;
        default:  reg_do_r <= 32'd0;
      endcase
    end
  end

  assign INT_REQ = int_req_r;
  assign INT_LVL = int_lvl_r;
  assign INT_VEC = int_vec_r;
  assign REG_DO  = reg_do_r;

endmodule

// File: tb/tb_intc_prio.sv
// tb_intc_prio: scoreboard bench for intc_prio (defaults NSRC=16,
// VEC_BASE=64, NMI_VEC=11). Stimulus pushes expected interrupt presentations
// and read data into queues; monitors pop and compare when INT_REQ rises or
// read data becomes valid.
module tb_intc_prio;

  typedef struct {
    logic [3:0] lvl;
    logic [7:0] vec;
  } irq_exp_t;

  typedef struct {
    string       nm;
    logic [31:0] val;
  } rd_exp_t;

  logic        CLK;
  logic        RST_N;
  logic        CE;
  logic        NMI_N;
  logic [15:0] SRC_IRQ;
  logic [3:0]  INT_MASK;
  logic        INT_REQ;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic        INT_ACK;
  logic [2:0]  REG_A;
  logic [31:0] REG_DI;
  logic [3:0]  REG_BE;
  logic        REG_WE;
  logic        REG_REQ;
  logic [31:0] REG_DO;

  irq_exp_t irq_q[$];
  rd_exp_t  rd_q[$];
  int       total = 0;
  int       bad   = 0;
  logic     req_prev = 1'b0;
  logic     rd_due   = 1'b0;

  intc_prio dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .NMI_N    (NMI_N),
    .SRC_IRQ  (SRC_IRQ),
    .INT_MASK (INT_MASK),
    .INT_REQ  (INT_REQ),
    .INT_LVL  (INT_LVL),
    .INT_VEC  (INT_VEC),
    .INT_ACK  (INT_ACK),
    .REG_A    (REG_A),
    .REG_DI   (REG_DI),
    .REG_BE   (REG_BE),
    .REG_WE   (REG_WE),
    .REG_REQ  (REG_REQ),
    .REG_DO   (REG_DO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // interrupt monitor: compare each new presentation against the queue
  always @(negedge CLK) begin
    if (INT_REQ === 1'b1 && req_prev !== 1'b1) begin
      if (irq_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL irq_unexpected: got lvl=%0d vec=%0d, none expected", INT_LVL, INT_VEC);
      end else begin
        irq_exp_t e;
        e = irq_q.pop_front();
        chk("irq_lvl", {28'd0, INT_LVL}, {28'd0, e.lvl});
        chk("irq_vec", {24'd0, INT_VEC}, {24'd0, e.vec});
      end
    end
    req_prev <= INT_REQ;
  end

  // read monitor: data is valid the CE cycle after a read request
  always @(posedge CLK) begin
    rd_due <= REG_REQ && !REG_WE && CE;
  end

  always @(negedge CLK) begin
    if (rd_due) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %h, none expected", REG_DO);
      end else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        chk(r.nm, REG_DO, r.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    REG_A = a; REG_DI = d; REG_BE = be; REG_WE = 1'b1; REG_REQ = 1'b1;
    @(negedge CLK);
    REG_WE = 1'b0; REG_REQ = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    rd_exp_t r;
    r.nm = nm; r.val = exp;
    rd_q.push_back(r);
    REG_A = a; REG_WE = 1'b0; REG_REQ = 1'b1;
    @(negedge CLK);
    REG_REQ = 1'b0;
  endtask

  task automatic expect_irq(input logic [3:0] lvl, input logic [7:0] vec);
    irq_exp_t e;
    e.lvl = lvl; e.vec = vec;
    irq_q.push_back(e);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (INT_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (INT_REQ !== 1'b1) begin
      bad++;
      $display("FAIL %s: INT_REQ still %b after %0d cycles, expected 1", nm, INT_REQ, n);
    end
  endtask

  task automatic wait_drop(input string nm);
    int n;
    n = 0;
    while (INT_REQ !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, {31'd0, INT_REQ}, 32'd0);
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    @(negedge CLK);
    INT_ACK = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; CE = 1'b1; NMI_N = 1'b1; SRC_IRQ = 16'd0; INT_MASK = 4'd3;
    INT_ACK = 1'b0; REG_A = 3'd0; REG_DI = 32'd0; REG_BE = 4'd0;
    REG_WE = 1'b0; REG_REQ = 1'b0;
    tick(3);
    chk("rst_req", {31'd0, INT_REQ}, 32'd0);
    chk("rst_lvl", {28'd0, INT_LVL}, 32'd0);
    chk("rst_vec", {24'd0, INT_VEC}, 32'd0);
    chk("rst_do", REG_DO, 32'd0);
    RST_N = 1'b1;
    tick(4);
    reg_rd(3'd6, 32'h0000_0002, "icr_after_reset");
    reg_rd(3'd0, 32'h0000_0000, "ipr0_after_reset");

    // clock enable low: a source pulse must not be seen
    reg_wr(3'd0, 32'h0000_0005, 4'hF);
    CE = 1'b0; SRC_IRQ[0] = 1'b1; tick(3);
    SRC_IRQ[0] = 1'b0; tick(3);
    CE = 1'b1; tick(5);
    chk("ce_gate_req", {31'd0, INT_REQ}, 32'd0);
    reg_rd(3'd5, 32'h0000_0000, "ce_gate_pend");

    // basic edge request, latency N+3, ACK clears pending
    expect_irq(4'd5, 8'd64);
    SRC_IRQ[0] = 1'b1; tick(1);
    SRC_IRQ[0] = 1'b0; tick(2);
    chk("lat_n2", {31'd0, INT_REQ}, 32'd0);
    tick(1);
    chk("lat_n3", {31'd0, INT_REQ}, 32'd1);
    reg_rd(3'd5, 32'h0000_0001, "pend_before_ack");
    ack();
    chk("ack_drop", {31'd0, INT_REQ}, 32'd0);
    reg_rd(3'd5, 32'h0000_0000, "pend_after_ack");

    // equal-priority tie: lower index first, HOLD lasts one cycle
    reg_wr(3'd0, 32'h0000_0700, 4'hF);
    reg_wr(3'd1, 32'hFFFF_FF70, 4'b0001);
    reg_rd(3'd1, 32'h0000_0070, "ipr1_byte_en");
    expect_irq(4'd7, 8'd66);
    expect_irq(4'd7, 8'd73);
    SRC_IRQ[2] = 1'b1; SRC_IRQ[9] = 1'b1; tick(1);
    SRC_IRQ[2] = 1'b0; SRC_IRQ[9] = 1'b0;
    wait_req("tie_first");
    ack();
    chk("hold_cycle0", {31'd0, INT_REQ}, 32'd0);
    tick(1);
    chk("hold_cycle1", {31'd0, INT_REQ}, 32'd0);
    tick(1);
    chk("tie_second_req", {31'd0, INT_REQ}, 32'd1);
    ack();
    reg_rd(3'd5, 32'h0000_0000, "pend_after_tie");
    reg_wr(3'd1, 32'h0000_0000, 4'hF);

    // NMI (falling edge) beats source 1 at level 9
    reg_wr(3'd0, 32'h0000_0090, 4'hF);
    expect_irq(4'd15, 8'd11);
    expect_irq(4'd9, 8'd65);
    SRC_IRQ[1] = 1'b1; NMI_N = 1'b0; tick(1);
    SRC_IRQ[1] = 1'b0;
    wait_req("nmi_first");
    ack();
    wait_req("src1_after_nmi");
    ack();
    NMI_N = 1'b1; tick(4);

    // NMIE=1: falling ignored, rising requests
    reg_wr(3'd6, 32'h0000_0001, 4'h1);
    NMI_N = 1'b0; tick(6);
    chk("nmi_fall_ignored", {31'd0, INT_REQ}, 32'd0);
    expect_irq(4'd15, 8'd11);
    NMI_N = 1'b1;
    wait_req("nmi_rise");
    reg_rd(3'd6, 32'h0000_0003, "icr_nmie_nmil");
    ack();
    reg_wr(3'd6, 32'h0000_0000, 4'h1);

    // level source 3: W1C ignored, withdrawal cancels, mask cancels
    reg_wr(3'd4, 32'h0000_0008, 4'hF);
    reg_wr(3'd0, 32'h0000_4000, 4'hF);
    INT_MASK = 4'd2;
    expect_irq(4'd4, 8'd67);
    SRC_IRQ[3] = 1'b1;
    wait_req("level_req");
    reg_wr(3'd5, 32'h0000_0008, 4'hF);
    reg_rd(3'd5, 32'h0000_0008, "level_w1c_ignored");
    chk("level_still_req", {31'd0, INT_REQ}, 32'd1);
    SRC_IRQ[3] = 1'b0;
    wait_drop("level_cancel");
    reg_rd(3'd5, 32'h0000_0000, "level_pend_gone");
    expect_irq(4'd4, 8'd67);
    SRC_IRQ[3] = 1'b1;
    wait_req("level_req2");
    INT_MASK = 4'd4; tick(1);
    chk("mask_cancel", {31'd0, INT_REQ}, 32'd0);
    tick(3);
    chk("masked_no_req", {31'd0, INT_REQ}, 32'd0);
    SRC_IRQ[3] = 1'b0; tick(5);
    INT_MASK = 4'd2; tick(3);
    reg_wr(3'd4, 32'h0000_0000, 4'hF);

    // W1C coincident with a new edge on source 5 keeps it set
    INT_MASK = 4'd15;
    SRC_IRQ[5] = 1'b1; tick(1);
    SRC_IRQ[5] = 1'b0; tick(4);
    reg_rd(3'd5, 32'h0000_0020, "pend5_set");
    SRC_IRQ[5] = 1'b1; tick(2);
    reg_wr(3'd5, 32'h0000_0020, 4'hF);
    SRC_IRQ[5] = 1'b0;
    reg_rd(3'd5, 32'h0000_0020, "pend5_set_wins");
    reg_wr(3'd5, 32'h0000_0020, 4'b1110);
    reg_rd(3'd5, 32'h0000_0020, "pend5_be_off");
    reg_wr(3'd5, 32'h0000_0020, 4'hF);
    reg_rd(3'd5, 32'h0000_0000, "pend5_w1c");

    // bits of unimplemented sources read 0
    reg_wr(3'd4, 32'hFFFF_FFFF, 4'hF);
    reg_rd(3'd4, 32'h0000_FFFF, "mode_nsrc");
    reg_wr(3'd4, 32'h0000_0000, 4'hF);
    reg_wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    reg_rd(3'd2, 32'h0000_0000, "ipr2_nsrc");
    reg_rd(3'd7, 32'h0000_0000, "word7");

    // reset while requesting
    reg_wr(3'd0, 32'h0000_0005, 4'hF);
    INT_MASK = 4'd0;
    expect_irq(4'd5, 8'd64);
    SRC_IRQ[0] = 1'b1; tick(1);
    SRC_IRQ[0] = 1'b0;
    wait_req("pre_reset_req");
    reg_rd(3'd5, 32'h0000_0001, "pre_reset_pend");
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, INT_REQ}, 32'd0);
    chk("rst_mid_lvl", {28'd0, INT_LVL}, 32'd0);
    chk("rst_mid_vec", {24'd0, INT_VEC}, 32'd0);
    chk("rst_mid_do", REG_DO, 32'd0);
    tick(2);
    RST_N = 1'b1;
    tick(2);
    reg_wr(3'd0, 32'h0000_0005, 4'hF);
    tick(8);
    chk("post_reset_no_req", {31'd0, INT_REQ}, 32'd0);
    reg_rd(3'd5, 32'h0000_0000, "post_reset_pend");

    tick(2);
    chk("irq_queue_empty", 32'(irq_q.size()), 32'd0);
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
